adc_scan_scheduler: RTL and testbench

- Round-robin ADC scan controller that sits between user logic and avr_interface.
- Drives the ADC channel select and consumes the new_sample / sample / sample_channel stream.
- Discards settling samples after each channel switch, then stores the last good 10-bit result per channel in a register bank.
- Flags channels that stop responding: the AVR may lag or stall.

---
 rtl/adc_scan_scheduler_if.sv | 31 +++
 rtl/adc_scan_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_scheduler_if.sv
// Signal bundle between the ADC scan scheduler, the AVR sample stream and the
// user-side result/readback logic. The scheduler takes the master view.
interface adc_scan_scheduler_if;
    logic        enable;
    logic [15:0] ch_mask;
    logic [3:0]  channel;
    logic        new_sample;
    logic [9:0]  sample;
    logic [3:0]  sample_channel;
    logic        result_valid;
    logic [9:0]  result;
    logic [3:0]  result_channel;
    logic        timeout;
    logic [3:0]  timeout_channel;
    logic [3:0]  rd_addr;
    logic [9:0]  rd_data;
    logic        rd_valid;
    logic        clear;

    modport master (
        input  enable, ch_mask, new_sample, sample, sample_channel, rd_addr, clear,
        output channel, result_valid, result, result_channel,
               timeout, timeout_channel, rd_data, rd_valid
    );

    modport slave (
        output enable, ch_mask, new_sample, sample, sample_channel, rd_addr, clear,
        input  channel, result_valid, result, result_channel,
               timeout, timeout_channel, rd_data, rd_valid
    );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Round-robin ADC scan controller. Selects channels in turn, drops settling
// samples after each switch, captures the next matching sample into a per-
// channel bank and abandons channels whose samples never arrive.
module adc_scan_scheduler #(
    parameter int DISCARD    = 1,
    parameter int TIMEOUT    = 20000,
    parameter int TIMER_SIZE = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    adc_scan_scheduler_if.master bus
);
    localparam logic [3:0] NO_CH  = 4'hF;
    localparam int         NUM_CH = 15;

    typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_WAIT} state_t;

    state_t                state_q, state_d;
    logic [3:0]            channel_q, channel_d;
    logic [3:0]            last_ch_q, last_ch_d;
    logic [3:0]            discard_q, discard_d;
    logic [TIMER_SIZE-1:0] timer_q, timer_d;

    logic                  capture;
    logic                  expire;
    logic                  match;
    logic [14:0]           em;
    logic [3:0]            next_ch;
    logic [4:0]            cand;

    logic                  result_valid_q;
    logic [9:0]            result_q;
    logic [3:0]            result_ch_q;
    logic                  timeout_q;
    logic [3:0]            timeout_ch_q;
    logic [9:0]            rd_data_q;
    logic                  rd_valid_q;

    logic [9:0]            bank_w [NUM_CH];
    logic [NUM_CH-1:0]     valid_w;

    // Channel 15 is the "no channel" code, so only bits 14:0 can be scanned.
    assign em    = bus.ch_mask[14:0];
    assign match = bus.new_sample && (bus.sample_channel == channel_q);

    // Next enabled channel after last_ch, wrapping 14->0; the last candidate
    // tried is last_ch itself so a lone enabled channel is picked again.
    always_comb begin
        next_ch = last_ch_q;
        cand    = 5'd0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = {1'b0, last_ch_q} + 5'(k);
            if (cand >= 5'(NUM_CH)) begin
                cand = cand - 5'(NUM_CH);
            end
            if (em[cand[3:0]]) begin
                next_ch = cand[3:0];
            end
        end
    end

    // Scan state and per-channel bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            channel_q <= NO_CH;
            last_ch_q <= 4'hE;
            discard_q <= 4'd0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            channel_q <= channel_d;
            last_ch_q <= last_ch_d;
            discard_q <= discard_d;
            timer_q   <= timer_d;
        end
    end

    // Scan sequencing: pick a channel, wait for its settled sample or give up.
    always_comb begin
        state_d   = state_q;
        channel_d = channel_q;
        last_ch_d = last_ch_q;
        discard_d = discard_q;
        timer_d   = timer_q;
        capture   = 1'b0;
        expire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                channel_d = NO_CH;
                if (bus.enable && (em != 15'd0)) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!bus.enable || (em == 15'd0)) begin
                    state_d   = ST_IDLE;
                    channel_d = NO_CH;
                end else begin
                    channel_d = next_ch;
                    last_ch_d = next_ch;
                    discard_d = 4'd0;
                    timer_d   = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (!bus.enable) begin
                    // Abort drops the channel without touching the bank.
                    state_d   = ST_IDLE;
                    channel_d = NO_CH;
                end else if (match) begin
                    if (discard_q < 4'(DISCARD)) begin
                        discard_d = discard_q + 4'd1;
                        timer_d   = '0;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_SELECT;
                    end
                end else if (timer_q == TIMER_SIZE'(TIMEOUT - 1)) begin
                    // A match in the same cycle has already won above.
                    expire  = 1'b1;
                    state_d = ST_SELECT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                channel_d = NO_CH;
            end
        endcase
    end

    // Capture and timeout reporting, one cycle after the decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid_q <= 1'b0;
            result_q       <= 10'd0;
            result_ch_q    <= 4'd0;
            timeout_q      <= 1'b0;
            timeout_ch_q   <= 4'd0;
        end else begin
            result_valid_q <= capture;
            timeout_q      <= expire;
            if (capture) begin
                result_q    <= bus.sample;
                result_ch_q <= channel_q;
            end
            if (expire) begin
                timeout_ch_q <= channel_q;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [9:0] bank_q;
            logic       valid_q;
            logic       hit;

            assign hit = capture && (channel_q == 4'(gi));

            // Per-channel slot: a capture writes data and sets valid (beating
            // clear); clear only drops valid and keeps the stored data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bank_q  <= 10'd0;
                    valid_q <= 1'b0;
                end else begin
                    if (hit) begin
                        bank_q  <= bus.sample;
                        valid_q <= 1'b1;
                    end else if (bus.clear) begin
                        valid_q <= 1'b0;
                    end
                end
            end

            assign bank_w[gi]  = bank_q;
            assign valid_w[gi] = valid_q;
        end
    endgenerate

    // Registered readback; a same-cycle capture shows up one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= 10'd0;
            rd_valid_q <= 1'b0;
        end else if (bus.rd_addr == NO_CH) begin
            rd_data_q  <= 10'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= bank_w[bus.rd_addr];
            rd_valid_q <= valid_w[bus.rd_addr];
        end
    end

    assign bus.channel         = channel_q;
    assign bus.result_valid    = result_valid_q;
    assign bus.result          = result_q;
    assign bus.result_channel  = result_ch_q;
    assign bus.timeout         = timeout_q;
    assign bus.timeout_channel = timeout_ch_q;
    assign bus.rd_data         = rd_data_q;
    assign bus.rd_valid        = rd_valid_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scenario bench for adc_scan_scheduler: a transaction-level model holds the
// expected bank contents, valid bits and round-robin position.
module tb_adc_scan_scheduler;
    localparam int DISCARD    = 1;
    localparam int TIMEOUT    = 16;
    localparam int TIMER_SIZE = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_scan_scheduler_if bus();

    adc_scan_scheduler #(
        .DISCARD(DISCARD), .TIMEOUT(TIMEOUT), .TIMER_SIZE(TIMER_SIZE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [9:0] m_bank [15];
    bit         m_valid [15];
    int         m_last;
    int         total = 0;
    int         bad = 0;

    // Round-robin rule: first enabled channel after 'last', wrapping 14->0.
    function automatic int next_sel(input logic [15:0] mask, input int last);
        for (int k = 1; k <= 15; k++) begin
            int c;
            c = (last + k) % 15;
            if (mask[c]) return c;
        end
        return 15;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) begin
            m_bank[i]  = 10'd0;
            m_valid[i] = 1'b0;
        end
        m_last = 14;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] tag, input logic [9:0] val);
        bus.new_sample     = 1'b1;
        bus.sample         = val;
        bus.sample_channel = tag;
        step();
        bus.new_sample     = 1'b0;
    endtask

    task automatic wait_channel(input int exp, input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.channel !== 4'(exp) && n < 3);
        total++;
        if (bus.channel !== 4'(exp)) begin
            bad++;
            $display("FAIL %s_select channel got=%0d want=%0d", name, bus.channel, exp);
        end
        m_last = exp;
    endtask

    task automatic do_capture(input int ch, input logic [9:0] val, input bit with_clear,
                              input string name);
        int stale;
        for (int d = 0; d < DISCARD; d++) begin
            strobe(4'(ch), 10'($urandom));
            total++;
            if (bus.result_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s_discard result_valid got=%0b want=0", name, bus.result_valid);
            end
        end
        stale = $urandom_range(0, 2);
        for (int s = 0; s < stale; s++) begin
            int tag;
            tag = $urandom_range(0, 14);
            if (tag == ch) tag = (tag + 1) % 15;
            strobe(4'(tag), 10'($urandom));
            total++;
            if (bus.result_valid !== 1'b0 || bus.timeout !== 1'b0) begin
                bad++;
                $display("FAIL %s_stale rv=%0b to=%0b want 0/0", name, bus.result_valid, bus.timeout);
            end
        end
        bus.clear = with_clear;
        strobe(4'(ch), val);
        bus.clear = 1'b0;
        if (with_clear) begin
            for (int i = 0; i < 15; i++) m_valid[i] = 1'b0;
        end
        m_bank[ch]  = val;
        m_valid[ch] = 1'b1;
        total++;
        if (bus.result_valid !== 1'b1 || bus.result !== val || bus.result_channel !== 4'(ch)) begin
            bad++;
            $display("FAIL %s_capture rv=%0b res=0x%03h ch=%0d want rv=1 res=0x%03h ch=%0d",
                     name, bus.result_valid, bus.result, bus.result_channel, val, ch);
        end
        $display("capture ch=%0d val=0x%03h clear=%0b", ch, val, with_clear);
    endtask

    task automatic readback_all(input string name);
        bus.enable = 1'b0;
        step();
        step();
        for (int a = 0; a < 16; a++) begin
            logic [9:0] ed;
            logic       ev;
            bus.rd_addr = 4'(a);
            step();
            ed = (a == 15) ? 10'd0 : m_bank[a];
            ev = (a == 15) ? 1'b0 : m_valid[a];
            total++;
            if (bus.rd_data !== ed || bus.rd_valid !== ev) begin
                bad++;
                $display("FAIL %s_rd[%0d] data=0x%03h valid=%0b want data=0x%03h valid=%0b",
                         name, a, bus.rd_data, bus.rd_valid, ed, ev);
            end
        end
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.ch_mask = 16'h0; bus.new_sample = 1'b0;
        bus.sample = 10'h0; bus.sample_channel = 4'h0; bus.rd_addr = 4'h0; bus.clear = 1'b0;
        model_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (bus.channel !== 4'hF) begin
            bad++; $display("FAIL reset_channel got=%0d want=15", bus.channel);
        end
        total++;
        if (bus.result_valid !== 1'b0 || bus.result !== 10'h0 || bus.result_channel !== 4'h0) begin
            bad++; $display("FAIL reset_result rv=%0b res=0x%03h ch=%0d want 0/0/0",
                            bus.result_valid, bus.result, bus.result_channel);
        end
        total++;
        if (bus.timeout !== 1'b0 || bus.timeout_channel !== 4'h0) begin
            bad++; $display("FAIL reset_timeout to=%0b ch=%0d want 0/0", bus.timeout, bus.timeout_channel);
        end
        total++;
        if (bus.rd_data !== 10'h0 || bus.rd_valid !== 1'b0) begin
            bad++; $display("FAIL reset_rd data=0x%03h valid=%0b want 0/0", bus.rd_data, bus.rd_valid);
        end
    endtask

    task automatic test_basic();
        bus.ch_mask = 16'h0003;
        bus.enable  = 1'b1;
        wait_channel(next_sel(16'h0003, m_last), "basic");
        do_capture(0, 10'h155, 1'b0, "basic");
        wait_channel(next_sel(16'h0003, m_last), "basic_next");
        bus.rd_addr = 4'h0;
        step();
        total++;
        if (bus.rd_data !== 10'h155 || bus.rd_valid !== 1'b1) begin
            bad++; $display("FAIL basic_rd data=0x%03h valid=%0b want 0x155/1", bus.rd_data, bus.rd_valid);
        end
    endtask

    task automatic test_stale();
        strobe(4'h0, 10'h3FF);
        total++;
        if (bus.result_valid !== 1'b0) begin
            bad++; $display("FAIL stale_tag result_valid got=%0b want=0", bus.result_valid);
        end
        do_capture(1, 10'h0F0, 1'b0, "stale");
        wait_channel(next_sel(16'h0003, m_last), "stale_wrap");
        readback_all("stale");
    endtask

    task automatic test_timeout();
        int early;
        logic [9:0] v;
        bus.ch_mask = 16'h0010;
        bus.rd_addr = 4'h4;
        bus.enable  = 1'b1;
        wait_channel(next_sel(16'h0010, m_last), "tmo");
        early = 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            if (i < TIMEOUT && bus.timeout !== 1'b0) early++;
        end
        total++;
        if (early != 0 || bus.timeout !== 1'b1 || bus.timeout_channel !== 4'h4) begin
            bad++; $display("FAIL tmo_pulse early=%0d to=%0b ch=%0d want early=0 to=1 ch=4",
                            early, bus.timeout, bus.timeout_channel);
        end
        wait_channel(4, "tmo_reselect");
        total++;
        if (bus.rd_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            bad++; $display("FAIL tmo_after rd_valid=%0b to=%0b want 0/0", bus.rd_valid, bus.timeout);
        end
        for (int d = 0; d < DISCARD; d++) strobe(4'h4, 10'($urandom));
        early = 0;
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            if (bus.timeout !== 1'b0 || bus.result_valid !== 1'b0) early++;
        end
        v = 10'($urandom);
        strobe(4'h4, v);
        m_bank[4]  = v;
        m_valid[4] = 1'b1;
        total++;
        if (early != 0 || bus.result_valid !== 1'b1 || bus.result !== v || bus.timeout !== 1'b0) begin
            bad++; $display("FAIL tmo_edge_match early=%0d rv=%0b res=0x%03h to=%0b want 0/1/0x%03h/0",
                            early, bus.result_valid, bus.result, bus.timeout, v);
        end
        $display("capture ch=4 val=0x%03h on last timer cycle", v);
        readback_all("tmo");
    endtask

    task automatic test_abort();
        int ch;
        bus.ch_mask = 16'h0003;
        bus.enable  = 1'b1;
        ch = next_sel(16'h0003, m_last);
        wait_channel(ch, "abort");
        for (int d = 0; d < DISCARD; d++) strobe(4'(ch), 10'($urandom));
        bus.enable = 1'b0;
        strobe(4'(ch), 10'h1AB);
        total++;
        if (bus.channel !== 4'hF || bus.result_valid !== 1'b0) begin
            bad++; $display("FAIL abort channel=%0d rv=%0b want 15/0", bus.channel, bus.result_valid);
        end
        readback_all("abort");
    endtask

    task automatic test_async_reset();
        bus.ch_mask = 16'h0003;
        bus.enable  = 1'b1;
        wait_channel(next_sel(16'h0003, m_last), "arst");
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.channel !== 4'hF) begin
            bad++; $display("FAIL arst_channel got=%0d want=15", bus.channel);
        end
        model_reset();
        bus.enable = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        readback_all("arst");
    endtask

    task automatic test_mask();
        int seen;
        bus.ch_mask = 16'h8000;
        bus.enable  = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.channel !== 4'hF) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL mask15_idle non_idle_cycles=%0d want=0", seen);
        end
        bus.ch_mask = 16'h4001;
        for (int i = 0; i < 4; i++) begin
            int e;
            e = next_sel(16'h4001, m_last);
            wait_channel(e, "mask_order");
            do_capture(e, 10'($urandom), 1'b0, "mask_order");
        end
        readback_all("mask");
    endtask

    task automatic test_clear();
        bus.ch_mask = 16'h0005;
        bus.enable  = 1'b1;
        wait_channel(next_sel(16'h0005, m_last), "clear");
        do_capture(m_last, 10'($urandom), 1'b0, "clear");
        wait_channel(next_sel(16'h0005, m_last), "clear");
        do_capture(m_last, 10'($urandom), 1'b1, "clear_same");
        readback_all("clear");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [15:0] mask;
            int n;
            mask = 16'($urandom);
            if (mask[14:0] == 15'd0) mask[$urandom_range(0, 14)] = 1'b1;
            bus.ch_mask = mask;
            bus.enable  = 1'b1;
            n = $urandom_range(2, 6);
            for (int t = 0; t < n; t++) begin
                int e;
                e = next_sel(mask, m_last);
                wait_channel(e, "rand");
                repeat ($urandom_range(0, 2)) step();
                do_capture(e, 10'($urandom), ($urandom_range(0, 3) == 0), "rand");
            end
            readback_all("rand");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stale();
        test_timeout();
        test_abort();
        test_async_reset();
        test_mask();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
